// File: rtl/mem_stage.sv
// mem_stage: dual-lane MEM stage; lane 1 extracts load data from sync SRAM with a stall hold buffer.
// Define MEM_MISALIGN_CHECK_EN to flag misaligned lane-1 lh/lhu/lw and suppress their writeback.
module mem_stage #(
   parameter int STALL_WD = 6,
   localparam int EX_TO_MEM_WD = 79,
   localparam int MEM_TO_WB_WD = 70,
   localparam int MEM_TO_RF_WD = 38
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [STALL_WD-1:0]       stall,
   input  logic [EX_TO_MEM_WD*2:0]   ex_to_mem_bus,
   input  logic [31:0]               data_sram_rdata,
   output logic [MEM_TO_WB_WD*2:0]   mem_to_wb_bus,
   output logic [MEM_TO_RF_WD*2-1:0] mem_to_rf_bus,
   output logic                      mem_excp
);
   localparam logic STOP = 1'b1;
   logic [EX_TO_MEM_WD*2:0] r;
   logic [31:0] hold_data;
   logic hold_valid;
   logic [EX_TO_MEM_WD-1:0] l1, l2;
   logic sw;
   logic [2:0] op;
   logic ram_en, sel, we;
   logic [3:0] wen;
   logic [4:0] wa;
   logic [31:0] res, pc, src, sh, load_data, wdata;
   logic [15:0] half;
   logic is_load;
   logic [MEM_TO_WB_WD-1:0] wb1;
   logic unused;
   assign {sw, l2, l1} = r;
   assign {op, ram_en, wen, sel, we, wa, res, pc} = l1;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r <= '0;
         hold_data <= '0;
         hold_valid <= 1'b0;
      end else begin
         if (flush) r <= '0;
         else if (stall[3] == STOP && stall[4] != STOP) r <= '0;
         else if (stall[3] != STOP) r <= ex_to_mem_bus;
         if (flush || stall[4] != STOP) hold_valid <= 1'b0;
         else if (!hold_valid && ram_en && wen == 4'b0) begin
            hold_valid <= 1'b1;
            hold_data <= data_sram_rdata;
         end
      end
   end
   // SRAM data is only valid for one cycle, so a stalled load reads the captured copy
   assign src = hold_valid ? hold_data : data_sram_rdata;
   assign sh = src >> {res[1:0], 3'b000};
   assign half = res[1] ? src[31:16] : src[15:0];
   assign is_load = op >= 3'd1 && op <= 3'd5;
   always_comb begin
      load_data = op == 3'd1 ? {{24{sh[7]}}, sh[7:0]} :
                  op == 3'd2 ? {24'b0, sh[7:0]} :
                  op == 3'd3 ? {{16{half[15]}}, half} :
                  op == 3'd4 ? {16'b0, half} : src;
      wdata = (sel && is_load) ? load_data : res;
   end
`ifdef MEM_MISALIGN_CHECK_EN
   assign mem_excp = ((op == 3'd3 || op == 3'd4) && res[0]) || (op == 3'd5 && res[1:0] != 2'b00);
`else
   assign mem_excp = 1'b0;
`endif
   assign wb1 = {we & ~mem_excp, wa, wdata, pc};
   assign mem_to_wb_bus = {sw, l2[MEM_TO_WB_WD-1:0], wb1};
   assign mem_to_rf_bus = {l2[MEM_TO_WB_WD-1:32], wb1[MEM_TO_WB_WD-1:32]};
   assign unused = ^{l2[EX_TO_MEM_WD-1:MEM_TO_WB_WD], stall, sh[31:8]};
endmodule
